// File: rtl/cam_pkg.sv
// Shared constants, FSM state encoding and colour conversion for the camera capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_pkg;

    localparam int SCREEN_WIDTH  = 176;
    localparam int SCREEN_HEIGHT = 144;
    localparam int ADDR_W        = 15;
    localparam int FRAME_PIXELS  = SCREEN_WIDTH * SCREEN_HEIGHT;

    // Column and row counters must hold SCREEN_WIDTH and SCREEN_HEIGHT themselves.
    localparam int COL_W = 8;
    localparam int ROW_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VSYNC,
        CAPTURE,
        DONE
    } cam_state_t;

    // RGB565 arrives MSB byte first: RRRRRGGG GGGBBBBB. Keep the top bits of each channel.
    function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] byte1, input logic [7:0] byte2);
        return {byte1[7:5], byte1[2:0], byte2[4:3]};
    endfunction

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Camera input bus plus frame-buffer write bus of the capture controller.
// Latency: n/a (wiring only).
// Backpressure: none; the camera streams and the RAM accepts every write.
interface cam_capture_ctrl_if;

    logic                       VSYNC;
    logic                       HREF;
    logic [7:0]                 DATA;
    logic                       W_EN;
    logic [cam_pkg::ADDR_W-1:0] WRITE_ADDRESS;
    logic [7:0]                 PIXEL_DATA;
    logic                       FRAME_DONE;
    logic                       BUSY;

    // The capture controller: consumes camera bytes, drives frame-buffer writes.
    modport master (
        input  VSYNC, HREF, DATA,
        output W_EN, WRITE_ADDRESS, PIXEL_DATA, FRAME_DONE, BUSY
    );

    // The camera / frame-buffer side.
    modport slave (
        output VSYNC, HREF, DATA,
        input  W_EN, WRITE_ADDRESS, PIXEL_DATA, FRAME_DONE, BUSY
    );

endinterface

// File: rtl/cam_byte_assembler.sv
// Pairs camera bytes into pixels and converts each RGB565 pair to RGB332.
// Latency: pixel valid combinationally in the cycle the second byte is presented.
// Backpressure: none; clr discards a half-assembled pixel.
module cam_byte_assembler
    import cam_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic       pix_vld,
    output logic [7:0] pix
);

    logic       phase;
    logic [7:0] byte1;

    // Toggle byte phase on each accepted byte and hold the first byte of the pair.
    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            phase <= 1'b0;
            byte1 <= '0;
        end else if (en) begin
            if (!phase) begin
                byte1 <= din;
            end
            phase <= ~phase;
        end
    end

    assign pix_vld = en && phase;
    assign pix     = rgb565_to_rgb332(byte1, din);

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame/line sequencer turning the camera byte stream into 176x144 RGB332 frame-buffer writes.
// Latency: W_EN/WRITE_ADDRESS/PIXEL_DATA registered, one cycle after the second byte of a pixel.
// Backpressure: none; out-of-window bytes are dropped. CAM_STATS_EN adds RED_COUNT/BLUE_COUNT.
module cam_capture_ctrl
    import cam_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    cam_capture_ctrl_if.master     cam
`ifdef CAM_STATS_EN
    ,
    output logic [ADDR_W-1:0]      RED_COUNT,
    output logic [ADDR_W-1:0]      BLUE_COUNT
`endif
);

    localparam logic [COL_W-1:0]  COL_LIMIT = COL_W'(SCREEN_WIDTH);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SCREEN_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W-1:0] LINE_LEN  = ADDR_W'(SCREEN_WIDTH);

    cam_state_t        state;
    logic              vsync_q;
    logic              href_q;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_cnt;

    logic              in_capture;
    logic              vsync_rise;
    logic              vsync_fall;
    logic              href_fall;
    logic              frame_start;
    logic              line_end;
    logic              pix_vld;
    logic [7:0]        pix;
    logic              wr;

    assign in_capture  = (state == CAPTURE);
    assign vsync_rise  = ~vsync_q & cam.VSYNC;
    assign vsync_fall  = vsync_q & ~cam.VSYNC;
    assign href_fall   = href_q & ~cam.HREF;
    assign frame_start = (state == WAIT_VSYNC) && vsync_fall;
    // A line only counts once at least one pixel landed in it.
    assign line_end    = in_capture && href_fall && (col != '0);
    // Row is always inside the window while capturing; the column may run past it.
    assign wr          = pix_vld && (col < COL_LIMIT);

    cam_byte_assembler u_asm (
        .CLK     (CLK),
        .RESET   (RESET),
        .clr     (!in_capture || href_fall),
        .en      (in_capture && cam.HREF),
        .din     (cam.DATA),
        .pix_vld (pix_vld),
        .pix     (pix)
    );

    // Frame FSM with line/column tracking, running write address and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state             <= IDLE;
            vsync_q           <= 1'b0;
            href_q            <= 1'b0;
            row               <= '0;
            col               <= '0;
            addr_cnt          <= '0;
            cam.W_EN          <= 1'b0;
            cam.WRITE_ADDRESS <= '0;
            cam.PIXEL_DATA    <= '0;
            cam.FRAME_DONE    <= 1'b0;
            cam.BUSY          <= 1'b0;
        end else begin
            vsync_q        <= cam.VSYNC;
            href_q         <= cam.HREF;
            cam.W_EN       <= 1'b0;
            cam.FRAME_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (ENABLE) begin
                        state <= WAIT_VSYNC;
                    end
                end
                WAIT_VSYNC: begin
                    if (frame_start) begin
                        state    <= CAPTURE;
                        row      <= '0;
                        col      <= '0;
                        addr_cnt <= '0;
                        cam.BUSY <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (wr) begin
                        cam.W_EN          <= 1'b1;
                        cam.WRITE_ADDRESS <= addr_cnt;
                        cam.PIXEL_DATA    <= pix;
                        col               <= col + COL_W'(1);
                        // Hold at the last pixel so the counter stays inside the buffer.
                        if (addr_cnt != ADDR_LAST) begin
                            addr_cnt <= addr_cnt + ADDR_W'(1);
                        end
                    end
                    if (vsync_rise || (line_end && row == ROW_LAST)) begin
                        state          <= DONE;
                        cam.FRAME_DONE <= 1'b1;
                        cam.BUSY       <= 1'b0;
                    end else if (line_end) begin
                        row      <= row + ROW_W'(1);
                        col      <= '0;
                        // Skip whatever a short line left unwritten so the next row starts aligned.
                        addr_cnt <= addr_cnt + (LINE_LEN - ADDR_W'(col));
                    end
                end
                DONE: begin
                    state <= ENABLE ? WAIT_VSYNC : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CAM_STATS_EN
    // Per-frame colour tallies; they hold after FRAME_DONE until the next frame starts.
    always_ff @(posedge CLK) begin
        if (RESET || frame_start) begin
            RED_COUNT  <= '0;
            BLUE_COUNT <= '0;
        end else if (wr) begin
            if (pix[7:5] >= 3'd5 && pix[1:0] == 2'b00) begin
                RED_COUNT <= RED_COUNT + ADDR_W'(1);
            end
            if (pix[1:0] == 2'b11 && pix[7:5] <= 3'd2) begin
                BLUE_COUNT <= BLUE_COUNT + ADDR_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: reset, overlong frame, latency, VSYNC end, reset mid-frame, enable drop.
// Latency: inputs change 1 time unit after CLK rise, outputs are read 1 unit after the next rise.
// Backpressure: none; a negedge monitor records every write into a shadow frame buffer.
module tb_cam_capture_ctrl;
    import cam_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    logic ENABLE;
`ifdef CAM_STATS_EN
    logic [ADDR_W-1:0] RED_COUNT;
    logic [ADDR_W-1:0] BLUE_COUNT;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    cam_capture_ctrl_if cam ();

    cam_capture_ctrl dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .cam        (cam)
`ifdef CAM_STATS_EN
        ,
        .RED_COUNT  (RED_COUNT),
        .BLUE_COUNT (BLUE_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Write monitor: records every write and FRAME_DONE pulse.
    int                wr_cnt    = 0;
    int                done_cnt  = 0;
    int                dup_cnt   = 0;
    int                oob_cnt   = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [7:0]        fb    [FRAME_PIXELS];
    bit                fb_wr [FRAME_PIXELS];

    always @(negedge CLK) begin
        int idx;
        if (cam.W_EN === 1'b1) begin
            wr_cnt++;
            last_addr = cam.WRITE_ADDRESS;
            idx = int'(cam.WRITE_ADDRESS);
            if (idx < FRAME_PIXELS) begin
                if (fb_wr[idx]) dup_cnt++;
                fb_wr[idx] = 1'b1;
                fb[idx]    = cam.PIXEL_DATA;
            end else begin
                oob_cnt++;
            end
        end
        if (cam.FRAME_DONE === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic vsync_pulse();
        cam.VSYNC = 1'b1;
        tick();
        tick();
        cam.VSYNC = 1'b0;
        tick();
    endtask

    // One HREF-high line of npix pixels (pixels below split use a1/a2), then one HREF-low cycle.
    task automatic drive_line(input int npix, input int split,
                              input logic [7:0] a1, input logic [7:0] a2,
                              input logic [7:0] b1, input logic [7:0] b2);
        cam.HREF = 1'b1;
        for (int p = 0; p < npix; p++) begin
            cam.DATA = (p < split) ? a1 : b1;
            tick();
            cam.DATA = (p < split) ? a2 : b2;
            tick();
        end
        cam.HREF = 1'b0;
        cam.DATA = 8'h00;
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1; ENABLE = 1'b0;
        cam.VSYNC = 1'b0; cam.HREF = 1'b0; cam.DATA = 8'h00;
        tick();
        tick();
        tests_run++; if (cam.W_EN !== 1'b0) begin tests_failed++; $display("FAIL rst_wen: got %b want 0", cam.W_EN); end
        tests_run++; if (cam.WRITE_ADDRESS !== '0) begin tests_failed++; $display("FAIL rst_addr: got %0d want 0", cam.WRITE_ADDRESS); end
        tests_run++; if (cam.PIXEL_DATA !== 8'h00) begin tests_failed++; $display("FAIL rst_pix: got %h want 00", cam.PIXEL_DATA); end
        tests_run++; if (cam.FRAME_DONE !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b want 0", cam.FRAME_DONE); end
        tests_run++; if (cam.BUSY !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", cam.BUSY); end
        RESET = 1'b0;
        ENABLE = 1'b1;
        tick();
        tick();
        tick();
        tests_run++; if (cam.BUSY !== 1'b0) begin tests_failed++; $display("FAIL wait_vsync_busy: got %b want 0", cam.BUSY); end
    endtask

    // 150 lines of 200 pixels: left 88 FF,E0 then 07,FF; only the 176x144 window lands.
    task automatic test_overlong_frame();
        int         base_done;
        int         pat_err;
        logic [7:0] exp_px;
        base_done = done_cnt;
        pat_err   = 0;
        vsync_pulse();
        tests_run++; if (cam.BUSY !== 1'b1) begin tests_failed++; $display("FAIL ovl_busy: got %b want 1", cam.BUSY); end
        for (int ln = 0; ln < 150; ln++) begin
            drive_line(200, 88, 8'hFF, 8'hE0, 8'h07, 8'hFF);
            if (ln == 142) begin
                tests_run++; if (cam.FRAME_DONE !== 1'b0) begin tests_failed++; $display("FAIL ovl_done_early: got %b want 0", cam.FRAME_DONE); end
            end
            if (ln == 143) begin
                tests_run++; if (cam.FRAME_DONE !== 1'b1) begin tests_failed++; $display("FAIL ovl_done_row144: got %b want 1", cam.FRAME_DONE); end
                tests_run++; if (wr_cnt != 25344) begin tests_failed++; $display("FAIL ovl_wr_at_done: got %0d want 25344", wr_cnt); end
`ifdef CAM_STATS_EN
                tests_run++; if (RED_COUNT !== 15'd12672) begin tests_failed++; $display("FAIL ovl_red: got %0d want 12672", RED_COUNT); end
                tests_run++; if (BLUE_COUNT !== 15'd12672) begin tests_failed++; $display("FAIL ovl_blue: got %0d want 12672", BLUE_COUNT); end
`endif
            end
            tick();
        end
        tests_run++; if (wr_cnt != 25344) begin tests_failed++; $display("FAIL ovl_wr_total: got %0d want 25344", wr_cnt); end
        tests_run++; if (last_addr !== 15'd25343) begin tests_failed++; $display("FAIL ovl_last_addr: got %0d want 25343", last_addr); end
        tests_run++; if (done_cnt - base_done != 1) begin tests_failed++; $display("FAIL ovl_done_cnt: got %0d want 1", done_cnt - base_done); end
        tests_run++; if (dup_cnt != 0 || oob_cnt != 0) begin tests_failed++; $display("FAIL ovl_addr_unique: got dup=%0d oob=%0d want 0/0", dup_cnt, oob_cnt); end
        for (int a = 0; a < FRAME_PIXELS; a++) begin
            exp_px = ((a % SCREEN_WIDTH) < 88) ? 8'hFC : 8'h1F;
            if (!fb_wr[a] || fb[a] !== exp_px) pat_err++;
        end
        tests_run++; if (pat_err != 0) begin tests_failed++; $display("FAIL ovl_pattern: got %0d bad pixels want 0", pat_err); end
    endtask

    task automatic test_latency();
        vsync_pulse();
        cam.HREF = 1'b1; cam.DATA = 8'h12;
        tick();
        tests_run++; if (cam.W_EN !== 1'b0) begin tests_failed++; $display("FAIL lat_first_byte: got %b want 0", cam.W_EN); end
        cam.DATA = 8'h34;
        tick();
        tests_run++; if (cam.W_EN !== 1'b1) begin tests_failed++; $display("FAIL lat_wen: got %b want 1", cam.W_EN); end
        tests_run++; if (cam.WRITE_ADDRESS !== 15'd0) begin tests_failed++; $display("FAIL lat_addr0: got %0d want 0", cam.WRITE_ADDRESS); end
        tests_run++; if (cam.PIXEL_DATA !== 8'h0A) begin tests_failed++; $display("FAIL lat_pix0: got %h want 0a", cam.PIXEL_DATA); end
        cam.HREF = 1'b0;
        tick();
        tests_run++; if (cam.W_EN !== 1'b0) begin tests_failed++; $display("FAIL lat_href_low: got %b want 0", cam.W_EN); end
        cam.HREF = 1'b1; cam.DATA = 8'hAB;
        tick();
        cam.DATA = 8'hCD;
        tick();
        tests_run++; if (cam.WRITE_ADDRESS !== 15'd176) begin tests_failed++; $display("FAIL short_line_addr: got %0d want 176", cam.WRITE_ADDRESS); end
        tests_run++; if (cam.PIXEL_DATA !== 8'hAD) begin tests_failed++; $display("FAIL lat_pix1: got %h want ad", cam.PIXEL_DATA); end
        cam.DATA = 8'hEE;
        tick();
        tests_run++; if (cam.W_EN !== 1'b0) begin tests_failed++; $display("FAIL odd_byte_wen: got %b want 0", cam.W_EN); end
        cam.HREF = 1'b0;
        tick();
        cam.HREF = 1'b1; cam.DATA = 8'h00;
        tick();
        cam.DATA = 8'hFF;
        tick();
        tests_run++; if (cam.W_EN !== 1'b1 || cam.WRITE_ADDRESS !== 15'd352) begin tests_failed++; $display("FAIL odd_discard_addr: got wen=%b addr=%0d want 1/352", cam.W_EN, cam.WRITE_ADDRESS); end
        tests_run++; if (cam.PIXEL_DATA !== 8'h03) begin tests_failed++; $display("FAIL odd_discard_pix: got %h want 03", cam.PIXEL_DATA); end
        cam.HREF = 1'b0;
        tick();
    endtask

    task automatic test_vsync_end();
        int base_wr;
        cam.VSYNC = 1'b1;
        tick();
        tests_run++; if (cam.FRAME_DONE !== 1'b1 || cam.BUSY !== 1'b0) begin tests_failed++; $display("FAIL vs_done1: got done=%b busy=%b want 1/0", cam.FRAME_DONE, cam.BUSY); end
        tick();
        tests_run++; if (cam.FRAME_DONE !== 1'b0) begin tests_failed++; $display("FAIL vs_done_pulse: got %b want 0", cam.FRAME_DONE); end
        cam.VSYNC = 1'b0;
        tick();
        tests_run++; if (cam.BUSY !== 1'b1) begin tests_failed++; $display("FAIL vs_restart_busy: got %b want 1", cam.BUSY); end
        base_wr = wr_cnt;
        for (int ln = 0; ln < 10; ln++) begin
            drive_line(SCREEN_WIDTH, SCREEN_WIDTH, 8'hF8, 8'h00, 8'hF8, 8'h00);
            tick();
        end
        cam.VSYNC = 1'b1;
        tick();
        tests_run++; if (cam.FRAME_DONE !== 1'b1) begin tests_failed++; $display("FAIL vs_done2: got %b want 1", cam.FRAME_DONE); end
        tests_run++; if (wr_cnt - base_wr != 1760 || last_addr !== 15'd1759) begin tests_failed++; $display("FAIL vs_10_lines: got %0d writes last %0d want 1760/1759", wr_cnt - base_wr, last_addr); end
`ifdef CAM_STATS_EN
        tests_run++; if (RED_COUNT !== 15'd1760 || BLUE_COUNT !== 15'd0) begin tests_failed++; $display("FAIL stats_red_frame: got red=%0d blue=%0d want 1760/0", RED_COUNT, BLUE_COUNT); end
`endif
        tick();
        cam.VSYNC = 1'b0;
        tick();
        cam.HREF = 1'b1; cam.DATA = 8'h07;
        tick();
        cam.DATA = 8'hFF;
        tick();
        tests_run++; if (cam.W_EN !== 1'b1 || cam.WRITE_ADDRESS !== 15'd0) begin tests_failed++; $display("FAIL vs_next_addr0: got wen=%b addr=%0d want 1/0", cam.W_EN, cam.WRITE_ADDRESS); end
        tests_run++; if (cam.PIXEL_DATA !== 8'h1F) begin tests_failed++; $display("FAIL vs_next_pix: got %h want 1f", cam.PIXEL_DATA); end
        cam.HREF = 1'b0;
        tick();
    endtask

    task automatic test_reset_midframe();
        int base_wr;
        int base_done;
        for (int ln = 1; ln < 50; ln++) begin
            drive_line(16, 16, 8'h12, 8'h34, 8'h12, 8'h34);
            tick();
        end
        cam.HREF = 1'b1; cam.DATA = 8'h12;
        tick();
        cam.DATA = 8'h34;
        tick();
        cam.DATA = 8'hAB;
        tick();
        cam.DATA = 8'hCD;
        tick();
        tests_run++; if (cam.W_EN !== 1'b1 || cam.WRITE_ADDRESS !== 15'd8801) begin tests_failed++; $display("FAIL row50_addr: got wen=%b addr=%0d want 1/8801", cam.W_EN, cam.WRITE_ADDRESS); end
        cam.DATA = 8'h55;
        tick();
        base_done = done_cnt;
        cam.DATA = 8'h66; RESET = 1'b1;
        tick();
        tests_run++; if (cam.W_EN !== 1'b0 || cam.WRITE_ADDRESS !== '0 || cam.PIXEL_DATA !== 8'h00) begin tests_failed++; $display("FAIL mid_rst_outs: got wen=%b addr=%0d pix=%h want 0/0/00", cam.W_EN, cam.WRITE_ADDRESS, cam.PIXEL_DATA); end
        tests_run++; if (cam.BUSY !== 1'b0 || cam.FRAME_DONE !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_ctrl: got busy=%b done=%b want 0/0", cam.BUSY, cam.FRAME_DONE); end
        RESET = 1'b0; cam.HREF = 1'b0;
        tick();
        tick();
        base_wr = wr_cnt;
        drive_line(4, 4, 8'hF8, 8'h00, 8'hF8, 8'h00);
        tick();
        tests_run++; if (wr_cnt != base_wr || cam.BUSY !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_no_capture: got %0d writes busy=%b want 0/0", wr_cnt - base_wr, cam.BUSY); end
        tests_run++; if (done_cnt != base_done) begin tests_failed++; $display("FAIL mid_rst_no_done: got %0d pulses want 0", done_cnt - base_done); end
        vsync_pulse();
        tests_run++; if (cam.BUSY !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_rearm: got %b want 1", cam.BUSY); end
        cam.HREF = 1'b1; cam.DATA = 8'hF8;
        tick();
        cam.DATA = 8'h00;
        tick();
        tests_run++; if (cam.W_EN !== 1'b1 || cam.WRITE_ADDRESS !== 15'd0 || cam.PIXEL_DATA !== 8'hE0) begin tests_failed++; $display("FAIL mid_rst_first_px: got wen=%b addr=%0d pix=%h want 1/0/e0", cam.W_EN, cam.WRITE_ADDRESS, cam.PIXEL_DATA); end
        cam.HREF = 1'b0;
        tick();
    endtask

    task automatic test_enable_drop();
        int base_wr;
        ENABLE = 1'b0;
        cam.VSYNC = 1'b1;
        tick();
        tests_run++; if (cam.FRAME_DONE !== 1'b1) begin tests_failed++; $display("FAIL en_drop_done: got %b want 1", cam.FRAME_DONE); end
        tick();
        cam.VSYNC = 1'b0;
        tick();
        tick();
        tests_run++; if (cam.BUSY !== 1'b0) begin tests_failed++; $display("FAIL en_drop_idle: got %b want 0", cam.BUSY); end
        base_wr = wr_cnt;
        drive_line(4, 4, 8'h07, 8'hFF, 8'h07, 8'hFF);
        tick();
        tests_run++; if (wr_cnt != base_wr) begin tests_failed++; $display("FAIL en_drop_writes: got %0d want 0", wr_cnt - base_wr); end
    endtask

    initial begin
        test_reset();
        test_overlong_frame();
        test_latency();
        test_vsync_end();
        test_reset_midframe();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Sequences the camera pixel stream (VSYNC/HREF/DATA, RGB565, two bytes per pixel, MSB byte first) into frame-buffer writes.
- Tracks frame and line boundaries, assembles byte pairs, and down-converts to RGB332.
- Generates write address, data and enable for the 176x144 frame-buffer RAM.
- Sits between the camera (or its simulator) and the frame-buffer RAM that the VGA reader scans.

Parameters:
- SCREEN_WIDTH, 176, pixels per line written to the frame buffer.
- SCREEN_HEIGHT, 144, lines per frame written to the frame buffer.
- ADDR_W, 15, width of the frame-buffer address; must satisfy 2^ADDR_W >= SCREEN_WIDTH*SCREEN_HEIGHT.

Ports:
- CLK  in  1  pixel-byte clock; all inputs are sampled on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  arm capture; while high, frames are captured back to back.
- VSYNC  in  1  camera frame sync; high between frames.
- HREF  in  1  camera line-valid.
- DATA  in  8  camera byte.
- W_EN  out  1  frame-buffer write strobe, one cycle per pixel.
- WRITE_ADDRESS  out  ADDR_W  equals row*SCREEN_WIDTH + col.
- PIXEL_DATA  out  8  RGB332 pixel.
- FRAME_DONE  out  1  one-cycle pulse when a frame completes.
- BUSY  out  1  high in the CAPTURE state.

Behaviour:
- Reset values: W_EN=0, WRITE_ADDRESS=0, PIXEL_DATA=0, FRAME_DONE=0, BUSY=0. Reset also clears row, col and byte phase, and sets state IDLE. Reset mid-frame discards the partial frame, with no FRAME_DONE.
- State IDLE: when ENABLE=1, go to WAIT_VSYNC.
- State WAIT_VSYNC: wait for VSYNC high, then VSYNC low (falling edge from a registered VSYNC). Then go to CAPTURE with row=0, col=0, phase=0.
- State CAPTURE (BUSY=1):
  - When HREF=1: phase 0 latches DATA as byte1 and sets phase=1. Phase 1 forms PIXEL_DATA={byte1[7:5], byte1[2:0], DATA[4:3]}.
  - W_EN, WRITE_ADDRESS and PIXEL_DATA are registered, so they are valid exactly one cycle after the second byte is sampled.
  - After a write, col increments and phase returns to 0.
  - Bytes with col >= SCREEN_WIDTH or row >= SCREEN_HEIGHT are dropped (W_EN stays 0).
  - HREF falling edge: if col>0 then row increments, col=0, phase=0. An odd byte left pending at that point is discarded.
  - Frame end occurs when row reaches SCREEN_HEIGHT, or when VSYNC rises, whichever happens first. Either way, go to DONE.
- State DONE: assert FRAME_DONE for one cycle. Then go to WAIT_VSYNC if ENABLE=1, else IDLE. A VSYNC rise that ended the frame still counts as the start of the next frame's sync, so WAIT_VSYNC sees VSYNC already high.
- ENABLE deassert during CAPTURE: the current frame completes, then the block returns to IDLE.
- Address arithmetic: keep a running address counter that is reset at frame start and incremented per write. No multiplier. The counter never exceeds SCREEN_WIDTH*SCREEN_HEIGHT-1.
- A short line (fewer than SCREEN_WIDTH pixels) leaves the remaining addresses of that line unwritten. The running address is realigned to row*SCREEN_WIDTH at each HREF fall by adding the missing count.

Optional Feature:
- Macro CAM_STATS_EN.
- Defined:
  - Adds outputs RED_COUNT[ADDR_W-1:0] and BLUE_COUNT[ADDR_W-1:0], both cleared at frame start.
  - A written pixel counts as red if PIXEL_DATA[7:5]>=5 and PIXEL_DATA[1:0]==0. It counts as blue if PIXEL_DATA[1:0]==3 and PIXEL_DATA[7:5]<=2.
  - Both counts are stable from the FRAME_DONE pulse until the next frame start.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package cam_pkg holds:
  - the constants SCREEN_WIDTH=176, SCREEN_HEIGHT=144, ADDR_W=15;
  - the state encoding {IDLE, WAIT_VSYNC, CAPTURE, DONE};
  - an rgb565_to_rgb332 function.
- One natural sub-module: cam_byte_assembler (phase toggle, byte1 latch, RGB332 output with valid). Frame, line and address control stays in the top.

Test Plan:
- Single frame, left half 0xFFE0 (bytes FF,E0) and right half 0x07FF (07,FF) -> writes at addresses 0..87 carry 0xFC, addresses 88..175 carry 0x1F. The pattern repeats per line, there are 25344 W_EN pulses in total, then one FRAME_DONE.
- Latency check: second byte sampled at cycle N -> W_EN=1 at N+1 with the correct address. No W_EN in cycles where HREF=0.
- Overlong line (200 pixels) and 150 lines -> only col<176 and row<144 are written. The last address is 25343, and FRAME_DONE fires when row reaches 144.
- VSYNC rises after line 10 -> FRAME_DONE pulses. The next frame captures from address 0 after VSYNC falls.
- RESET asserted at line 50 -> all outputs 0 on the next cycle with no FRAME_DONE. With ENABLE high, capture restarts only after a full VSYNC high-to-low sequence.
- CAM_STATS_EN: frame of all 0xF800 (bytes F8,00 -> 0xE0) -> RED_COUNT=25344 and BLUE_COUNT=0 at FRAME_DONE.
